mod10_dec: RTL and testbench
============================

Name: mod10_dec

Overview:
- Multi-digit BCD down-counter. It is the decrementing counterpart of the mod10 up-counter (`incremento` in, `contador10` carry out).
- It consumes `decremento` pulses and emits a one-cycle borrow pulse, `prestamo`, on wrap from all-zeros to all-nines.
- Borrow chains internally across digits. `prestamo` cascades to a higher-order instance the same way `contador10` cascades up-counters.
- Adds parallel BCD load with digit validation and a saturate-at-zero mode for countdown timers.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- WRAP, 1, 1 = wrap 0..0 -> 9..9 with `prestamo` pulse; 0 = saturate at 0..0 and assert `fin`.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- carga  input  1  load request; loads `valor_carga` on the next edge.
- valor_carga  input  4*DIGITS  BCD load value, digit i at bits [4i+3:4i].
- decremento  input  1  decrement request, one count per cycle sampled high.
- cuenta  output  4*DIGITS  current BCD count, registered.
- prestamo  output  1  borrow-out pulse, registered, one cycle wide.
- cero  output  1  high while `cuenta` == 0, registered.
- fin  output  1  WRAP=0 only: high while saturated at zero after a countdown (tied 0 when WRAP=1).
- error_carga  output  1  one-cycle pulse, registered: last load contained a non-BCD digit.

Behaviour:
- Reset:
  - On a rising edge with rst == 0: `cuenta` = 0, `prestamo` = 0, `fin` = 0, `error_carga` = 0, `cero` = 1, FSM -> IDLE.
  - Reset has priority over all inputs, including mid-countdown.
- Latency: one cycle. An input sampled at edge N is reflected in every output after edge N.
- Priority per edge: rst, then carga, then decremento. When carga and decremento are both high, the load wins and no decrement occurs.
- Load:
  - Each digit > 9 is clamped to 9 and `error_carga` pulses for one cycle. Valid digits load unchanged.
  - A load clears `fin`.
  - FSM -> CONTANDO if the loaded value is != 0, else IDLE.
- Decrement arithmetic, digit by digit from digit 0:
  - Digit i decrements if decremento is high and all lower digits are 0; otherwise it holds.
  - A digit at 0 that decrements becomes 9.
  - No binary arithmetic on the full vector; each digit is always in 0..9.
- WRAP=1, count at 0..0 with decremento:
  - `cuenta` becomes 9..9 and `prestamo` = 1 for exactly that cycle.
  - `prestamo` is 0 on every other cycle, including back-to-back decrements that do not wrap.
- WRAP=0:
  - Decrement from 0..1 -> 0..0 asserts `fin` on the same edge that `cero` rises.
  - Further decrements hold 0..0, keep `fin` high and never pulse `prestamo`.
  - `fin` clears only on carga or reset.
- FSM, states IDLE, CONTANDO, AGOTADO:
  - IDLE: count is 0 and no countdown has finished. decremento with WRAP=1 -> CONTANDO (count becomes 9..9). decremento with WRAP=0 stays IDLE.
  - CONTANDO: count != 0. Reaching 0 via decrement -> AGOTADO.
  - AGOTADO: `fin` = 1 when WRAP=0. With WRAP=1, a decrement -> CONTANDO and pulses `prestamo`.
  - carga from any state: -> CONTANDO if the loaded value is nonzero, else IDLE.
- `cero` tracks `cuenta` == 0 combinationally from the registered count, so it is glitch-free and aligned with `cuenta`.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
1. Reset: hold rst=0 for 2 edges with carga=1, decremento=1 -> `cuenta`=0x00, `cero`=1, `prestamo`=0, `fin`=0, `error_carga`=0.
2. DIGITS=2, WRAP=1, load 0x12, then 13 consecutive decremento cycles:
   - Counts 11, 10, 09, ..., 01, 00, 99.
   - `cero`=1 only on the 00 cycle.
   - `prestamo`=1 only on the cycle showing 99.
3. Decrement across a digit boundary: load 0x30, one decremento -> `cuenta`=0x29, `prestamo`=0. Next cycle decremento=0 -> holds 0x29.
4. Simultaneous carga and decremento: from 0x45, carga=1 with valor_carga=0x07 and decremento=1 -> `cuenta`=0x07 next cycle (no decrement applied).
5. Invalid load: valor_carga=0xA3 -> `cuenta`=0x93 and `error_carga`=1 for one cycle. valor_carga=0xFF -> `cuenta`=0x99 and `error_carga` pulses.
6. WRAP=0 with a mid-operation reset:
   - Load 0x02, 3 decrements -> 01, 00, 00. `fin` rises with 00 and stays 1; `prestamo` never asserts.
   - Reload 0x05 -> `fin`=0.
   - Decrement once to 0x04, then assert rst=0 for one edge -> `cuenta`=0x00, `fin`=0, `cero`=1.

Source files
------------

// File: rtl/mod10_dec_if.sv
// Load/decrement request bundle and BCD count status of mod10_dec.
// master drives the requests, slave is the counter.
interface mod10_dec_if #(
    parameter int DIGITS = 2
);
    logic                  carga;
    logic [4*DIGITS-1:0]   valor_carga;
    logic                  decremento;
    logic [4*DIGITS-1:0]   cuenta;
    logic                  prestamo;
    logic                  cero;
    logic                  fin;
    logic                  error_carga;

    modport master (
        output carga,
        output valor_carga,
        output decremento,
        input  cuenta,
        input  prestamo,
        input  cero,
        input  fin,
        input  error_carga
    );

    modport slave (
        input  carga,
        input  valor_carga,
        input  decremento,
        output cuenta,
        output prestamo,
        output cero,
        output fin,
        output error_carga
    );
endinterface

// File: rtl/mod10_dec.sv
// Multi-digit BCD down-counter with validated parallel load,
// borrow-out pulse on wrap, or saturate-at-zero countdown mode.
module mod10_dec #(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    mod10_dec_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONTANDO,
        AGOTADO
    } estado_t;

    estado_t        estado;
    logic [W-1:0]   val_load;
    logic           load_bad;
    logic [W-1:0]   val_dec;
    logic           borrow;
    logic [3:0]     dig;
    logic [3:0]     ldig;

    // Per-digit clamp of the load word and ripple borrow for decrement.
    always_comb begin
        val_load = '0;
        load_bad = 1'b0;
        val_dec  = '0;
        borrow   = 1'b1;
        dig      = '0;
        ldig     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            ldig = bus.valor_carga[4*i +: 4];
            if (ldig > 4'd9) begin
                val_load[4*i +: 4] = 4'd9;
                load_bad = 1'b1;
            end else begin
                val_load[4*i +: 4] = ldig;
            end
            dig = bus.cuenta[4*i +: 4];
            if (borrow) begin
                val_dec[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end else begin
                val_dec[4*i +: 4] = dig;
            end
            borrow = borrow & (dig == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.cuenta      <= '0;
            bus.prestamo    <= 1'b0;
            bus.fin         <= 1'b0;
            bus.error_carga <= 1'b0;
            estado          <= IDLE;
        end else begin
            bus.prestamo    <= 1'b0;
            bus.error_carga <= 1'b0;
            if (bus.carga) begin
                bus.cuenta      <= val_load;
                bus.error_carga <= load_bad;
                bus.fin         <= 1'b0;
                estado          <= (val_load != '0) ? CONTANDO : IDLE;
            end else if (bus.decremento) begin
                unique case (estado)
                    IDLE, AGOTADO: begin
                        // At zero: wrap to all nines, or hold when saturating.
                        if (WRAP != 0) begin
                            bus.cuenta   <= val_dec;
                            bus.prestamo <= 1'b1;
                            estado       <= CONTANDO;
                        end
                    end
                    CONTANDO: begin
                        bus.cuenta <= val_dec;
                        if (val_dec == '0) begin
                            estado  <= AGOTADO;
                            bus.fin <= (WRAP == 0) ? 1'b1 : 1'b0;
                        end
                    end
                    default: estado <= IDLE;
                endcase
            end
        end
    end

    assign bus.cero = (bus.cuenta == '0);
endmodule

// File: tb/tb_mod10_dec.sv
// Scoreboard bench: WRAP=1 and WRAP=0 counters share stimulus and are
// compared against an integer-valued reference model.
module tb_mod10_dec;
    localparam int D    = 2;
    localparam int MAXV = 99;

    typedef struct {
        logic [7:0] c;
        logic       p;
        logic       z;
        logic       f;
        logic       e;
    } exp_t;

    logic clk;
    logic rst;

    mod10_dec_if #(.DIGITS(D)) if1 ();
    mod10_dec_if #(.DIGITS(D)) if0 ();

    mod10_dec #(.DIGITS(D), .WRAP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    mod10_dec #(.DIGITS(D), .WRAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t q1[$];
    exp_t q0[$];
    int   v1 = 0;
    int   v0 = 0;
    bit   f1 = 0;
    bit   f0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [7:0] b);
        int hi;
        int lo;
        hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
        lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic void model(
        input  bit         r,
        input  bit         cg,
        input  logic [7:0] val,
        input  bit         dc,
        input  bit         wrap,
        inout  int         v,
        inout  bit         fn,
        output exp_t       e
    );
        e.p = 1'b0;
        e.e = 1'b0;
        if (!r) begin
            v  = 0;
            fn = 0;
        end else if (cg) begin
            v   = bcd2int(val);
            fn  = 0;
            e.e = (val[7:4] > 4'd9) || (val[3:0] > 4'd9);
        end else if (dc) begin
            if (v == 0) begin
                if (wrap) begin
                    v   = MAXV;
                    e.p = 1'b1;
                end
            end else begin
                v = v - 1;
                if (v == 0 && !wrap) fn = 1;
            end
        end
        e.c = int2bcd(v);
        e.z = (v == 0);
        e.f = fn;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(
        input bit         r,
        input bit         cg,
        input logic [7:0] val,
        input bit         dc
    );
        exp_t e1;
        exp_t e0;
        @(negedge clk);
        rst             = r;
        if1.carga       = cg;
        if1.valor_carga = val;
        if1.decremento  = dc;
        if0.carga       = cg;
        if0.valor_carga = val;
        if0.decremento  = dc;
        @(posedge clk);
        model(r, cg, val, dc, 1'b1, v1, f1, e1);
        model(r, cg, val, dc, 1'b0, v0, f0, e0);
        q1.push_back(e1);
        q0.push_back(e0);
    endtask

    // Monitor: every edge presents a new registered output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("w1.cuenta", int'(if1.cuenta), int'(e.c));
                check("w1.prestamo", int'(if1.prestamo), int'(e.p));
                check("w1.cero", int'(if1.cero), int'(e.z));
                check("w1.fin", int'(if1.fin), int'(e.f));
                check("w1.error_carga", int'(if1.error_carga), int'(e.e));
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("w0.cuenta", int'(if0.cuenta), int'(e.c));
                check("w0.prestamo", int'(if0.prestamo), int'(e.p));
                check("w0.cero", int'(if0.cero), int'(e.z));
                check("w0.fin", int'(if0.fin), int'(e.f));
                check("w0.error_carga", int'(if0.error_carga), int'(e.e));
            end
        end
    end

    initial begin
        rst             = 1'b0;
        if1.carga       = 1'b0;
        if1.valor_carga = '0;
        if1.decremento  = 1'b0;
        if0.carga       = 1'b0;
        if0.valor_carga = '0;
        if0.decremento  = 1'b0;

        // Reset dominates load and decrement.
        step(0, 1, 8'h55, 1);
        step(0, 1, 8'h55, 1);

        // Countdown through zero.
        step(1, 1, 8'h12, 0);
        for (int i = 0; i < 13; i++) step(1, 0, 8'h00, 1);

        // Digit boundary and hold.
        step(1, 1, 8'h30, 0);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        // Load beats decrement.
        step(1, 1, 8'h45, 0);
        step(1, 1, 8'h07, 1);

        // Non-BCD loads clamp.
        step(1, 1, 8'hA3, 0);
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'hFF, 0);
        step(1, 0, 8'h00, 0);

        // Saturation, reload, mid-count reset.
        step(1, 1, 8'h02, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1);
        step(1, 1, 8'h05, 0);
        step(1, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Decrement from fresh zero.
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 5 && (q1.size() > 0 || q0.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0",
                     q1.size() + q0.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
